// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the cache-refill request arbiter in front of axi_m.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic OWN_DC = 1'b0;
  localparam logic OWN_IC = 1'b1;

  localparam logic [31:0] LINE_OFFSET_MASK = 32'hFFFF_FFF0;

endpackage

// File: rtl/mem_req_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto the axi_m request port, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise D-cache has fixed priority.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_req_i,
  input  logic [ADDR_W-1:0] icache_addr_i,
  output logic [LINE_W-1:0] icache_rdata_o,
  output logic              icache_ack_o,
  input  logic              dcache_req_i,
  input  logic              dcache_rw_i,
  input  logic [ADDR_W-1:0] dcache_addr_i,
  input  logic [LINE_W-1:0] dcache_wdata_i,
  output logic [LINE_W-1:0] dcache_rdata_o,
  output logic              dcache_ack_o,
  output logic              Rvcore_valid_req_o,
  output logic              Rvcore_rw_o,
  output logic [ADDR_W-1:0] Rvcore_addr_o,
  output logic [LINE_W-1:0] Rvcore_data_o,
  input  logic [LINE_W-1:0] axi_data_i,
  input  logic              axi_rd_over_i,
  input  logic              axi_wr_over_i
);

  // Mask sized to the address width; only the 16-byte line offset is cleared.
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(~LINE_OFFSET_MASK);

  state_e             state_q;
  logic               owner_q;
  logic               valid_q;
  logic               rw_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LINE_W-1:0]  data_q;
  logic               ic_ack_q;
  logic               dc_ack_q;
  logic [LINE_W-1:0]  ic_rdata_q;
  logic [LINE_W-1:0]  dc_rdata_q;

  logic               any_req;
  logic               owner_d;
  logic               rw_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [LINE_W-1:0]  wdata_d;
  logic               done_d;

`ifdef MEM_ARB_RR_EN
  logic last_grant_q;
  // On contention the port that did not win last time goes first.
  assign owner_d = (icache_req_i && (!dcache_req_i || last_grant_q == OWN_DC)) ? OWN_IC : OWN_DC;
`else
  assign owner_d = (icache_req_i && !dcache_req_i) ? OWN_IC : OWN_DC;
`endif

  assign any_req = icache_req_i | dcache_req_i;
  assign rw_d    = (owner_d == OWN_IC) ? RW_READ : dcache_rw_i;
  assign addr_d  = ((owner_d == OWN_IC) ? icache_addr_i : dcache_addr_i) & ADDR_MASK;
  assign wdata_d = (owner_d == OWN_DC && dcache_rw_i == RW_WRITE) ? dcache_wdata_i : '0;

  // Only the completion pulse matching the transaction type is honoured.
  assign done_d  = (rw_q == RW_READ) ? axi_rd_over_i : axi_wr_over_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_DC;
      valid_q    <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      ic_ack_q   <= 1'b0;
      dc_ack_q   <= 1'b0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= OWN_IC;
`endif
    end else begin
      valid_q  <= 1'b0;
      ic_ack_q <= 1'b0;
      dc_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q <= owner_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            data_q  <= wdata_d;
            valid_q <= 1'b1;
            state_q <= ISSUE;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= owner_d;
`endif
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (done_d) begin
            if (rw_q == RW_READ) begin
              if (owner_q == OWN_IC) ic_rdata_q <= axi_data_i;
              else                   dc_rdata_q <= axi_data_i;
            end
            ic_ack_q <= (owner_q == OWN_IC);
            dc_ack_q <= (owner_q == OWN_DC);
            state_q  <= RESP;
          end
        end
        RESP: begin
          rw_q    <= 1'b0;
          addr_q  <= '0;
          data_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Rvcore_valid_req_o = valid_q;
  assign Rvcore_rw_o        = rw_q;
  assign Rvcore_addr_o      = addr_q;
  assign Rvcore_data_o      = data_q;
  assign icache_ack_o       = ic_ack_q;
  assign dcache_ack_o       = dc_ack_q;
  assign icache_rdata_o     = ic_rdata_q;
  assign dcache_rdata_o     = dc_rdata_q;

endmodule
